// File: rtl/systola_pkg.sv
// Shared types and sizing for the systolic feed path (scheduler + input-buffer controller).
package systola_pkg;

    // Array dimension shared with the input-buffer controller.
    localparam int SYSTOLA_ROWS = 8;
    localparam int SYSTOLA_KMAX = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

    // Stream phase length: K data beats plus ROWS-1 cycles of skew fill at the
    // buffers and ROWS-1 more for the last product to cross the array.
    function automatic int stream_len(input int k, input int rows);
        return k + 2 * (rows - 1);
    endfunction

endpackage

// File: rtl/systola_cycle_cnt.sv
// Loadable up-counter with terminal-count compare; used for the load and stream phases.
module systola_cycle_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Load takes priority over increment so a phase can restart on its first cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en)   cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/core_feed_sched.sv
// Tile scheduler: loads K vectors into the skewed input buffers, then streams them
// through the PE array and pulses done.
// Optional underrun check on row-0 buffer empties: define SYSTOLA_UNDERRUN_CHK_EN.
module core_feed_sched
    import systola_pkg::*;
#(
    parameter int ROWS = SYSTOLA_ROWS,
    parameter int KMAX = SYSTOLA_KMAX,
    parameter int CNTW = $clog2(KMAX + 2 * ROWS)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [CNTW-1:0] klen,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            buf_write,
    output logic            buf_read,
    input  logic [ROWS-1:0] aemptys,
    input  logic [ROWS-1:0] wemptys,
    output logic            pe_en,
    output logic            pe_clr,
    output logic            busy,
    output logic            done,
    output logic            underrun
);

    sched_state_t    state;
    logic [CNTW-1:0] k_q;
    logic            start_ok;
    logic            accept;
    logic [CNTW-1:0] ld_cnt, st_cnt;
    logic            ld_tc, st_tc;
    logic [CNTW-1:0] ld_last, st_last, rd_last;
    logic            unused_sink;

    assign start_ok  = start && (klen != '0) && (klen <= CNTW'(KMAX));
    assign accept    = in_valid & in_ready;
    assign buf_write = accept;

    // Terminal counts derived from the latched K; only consulted in their own phase.
    assign ld_last = k_q - 1'b1;
    assign st_last = CNTW'(stream_len(int'(k_q), ROWS) - 1);
    assign rd_last = k_q + CNTW'(ROWS - 2);

    systola_cycle_cnt #(.W(CNTW)) u_ld_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     ((state == IDLE) && start_ok),
        .load_val ('0),
        .en       (accept),
        .term     (ld_last),
        .cnt      (ld_cnt),
        .tc       (ld_tc)
    );

    systola_cycle_cnt #(.W(CNTW)) u_st_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (accept && ld_tc),
        .load_val ('0),
        .en       ((state == STREAM) && !st_tc),
        .term     (st_last),
        .cnt      (st_cnt),
        .tc       (st_tc)
    );

    // Phase sequencing; outputs are registered so each reflects the cycle it is in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            k_q      <= '0;
            in_ready <= 1'b0;
            buf_read <= 1'b0;
            pe_en    <= 1'b0;
            pe_clr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done   <= 1'b0;
            pe_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        k_q      <= klen;
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept && ld_tc) begin
                        state    <= STREAM;
                        in_ready <= 1'b0;
                        pe_en    <= 1'b1;
                        pe_clr   <= 1'b1;
                        buf_read <= 1'b1;
                    end
                end
                STREAM: begin
                    if (st_tc) begin
                        state    <= DONE;
                        pe_en    <= 1'b0;
                        buf_read <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        // keep reading through cycle K+ROWS-2 to drain the deepest skewed row
                        buf_read <= (st_cnt < rd_last);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SYSTOLA_UNDERRUN_CHK_EN
    // Sticky flag: a read of real data (first K stream cycles) hit an empty row-0 buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            underrun <= 1'b0;
        else if ((state == STREAM) && buf_read && (st_cnt < k_q) && (aemptys[0] | wemptys[0]))
            underrun <= 1'b1;
    end
`else
    assign underrun = 1'b0;
`endif

    // Only row 0 empties matter to the check; the load count is consumed through ld_tc.
    assign unused_sink = ^{aemptys, wemptys, ld_cnt};

endmodule

// File: tb/tb_core_feed_sched.sv
// Directed bench for core_feed_sched (ROWS=8, KMAX=256). Build with
// SYSTOLA_UNDERRUN_CHK_EN defined to expect the underrun flag to fire.
module tb_core_feed_sched;

    localparam int ROWS = 8;
    localparam int KMAX = 256;
    localparam int CNTW = 9;
`ifdef SYSTOLA_UNDERRUN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic [CNTW-1:0] klen;
    logic            in_valid;
    logic            in_ready, buf_write, buf_read, pe_en, pe_clr, busy, done, underrun;
    logic [ROWS-1:0] aemptys, wemptys;

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    core_feed_sched #(.ROWS(ROWS), .KMAX(KMAX), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .klen      (klen),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .buf_write (buf_write),
        .buf_read  (buf_read),
        .aemptys   (aemptys),
        .wemptys   (wemptys),
        .pe_en     (pe_en),
        .pe_clr    (pe_clr),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    wire [7:0] obs = {underrun, in_ready, buf_write, buf_read, pe_en, pe_clr, busy, done};

    // Expected outputs for cycle i of a tile (i=0 is the first LOAD cycle), given the
    // first STREAM cycle s0, K, the cycle underrun is first seen high (-1: never), and in_valid.
    function automatic logic [7:0] exp_out(input int i, input int s0, input int k,
                                           input int ur, input logic iv);
        int dn;
        dn = s0 + k + 2 * (ROWS - 1);
        exp_out = {(ur >= 0) && (i >= ur),
                   i < s0,
                   (i < s0) && iv,
                   (i >= s0) && (i < s0 + k + ROWS - 1),
                   (i >= s0) && (i < dn),
                   i == s0,
                   i <= dn,
                   i == dn};
    endfunction

    task automatic begin_tile(input int k);
        @(negedge clk);
        start = 1'b1;
        klen  = CNTW'(k);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; klen = '0; in_valid = 1'b0;
        aemptys = '0; wemptys = '0;
        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if (obs !== 8'h00) begin
            fails++;
            $display("FAIL reset: got %b want %b", obs, 8'h00);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        vecs++;
        if (obs !== 8'h00) begin
            fails++;
            $display("FAIL reset_release: got %b want %b", obs, 8'h00);
        end
    endtask

    // K=4, in_valid held: LOAD idx 0..3, STREAM idx 4..21, done idx 22.
    task automatic test_basic();
        logic [7:0] e;
        begin_tile(4);
        for (int i = 0; i < 26; i++) begin
            in_valid = 1'b1;
            #1;
            e = exp_out(i, 4, 4, -1, 1'b1);
            vecs++;
            if (obs !== e) begin
                fails++;
                $display("FAIL basic cyc %0d: got %b want %b", i, obs, e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // K=3, in_valid 1,0,0,1,0,1: third accept at idx 5, STREAM from idx 6.
    task automatic test_stall();
        logic [5:0] pat;
        logic [7:0] e;
        logic       iv;
        pat = 6'b101001;
        begin_tile(3);
        for (int i = 0; i < 27; i++) begin
            iv = (i < 6) ? pat[i] : 1'b0;
            in_valid = iv;
            #1;
            e = exp_out(i, 6, 3, -1, iv);
            vecs++;
            if (obs !== e) begin
                fails++;
                $display("FAIL stall cyc %0d: got %b want %b", i, obs, e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Illegal klen ignored; start while busy (LOAD, STREAM, DONE) ignored.
    task automatic test_ignore();
        logic [7:0] e;
        int bad [2];
        bad[0] = 0;
        bad[1] = KMAX + 1;
        for (int b = 0; b < 2; b++) begin
            begin_tile(bad[b]);
            for (int i = 0; i < 3; i++) begin
                #1;
                vecs++;
                if (obs !== 8'h00) begin
                    fails++;
                    $display("FAIL ignore_klen%0d cyc %0d: got %b want %b", bad[b], i, obs, 8'h00);
                end
                @(negedge clk);
            end
        end
        begin_tile(1);
        klen = CNTW'(5);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            start = (i == 0) || (i == 5) || (i == 16);
            #1;
            e = exp_out(i, 1, 1, -1, 1'b1);
            vecs++;
            if (obs !== e) begin
                fails++;
                $display("FAIL ignore_busy cyc %0d: got %b want %b", i, obs, e);
            end
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_kmax();
        logic [7:0] e;
        begin_tile(KMAX);
        for (int i = 0; i < 2 * KMAX + 2 * (ROWS - 1) + 3; i++) begin
            in_valid = 1'b1;
            #1;
            e = exp_out(i, KMAX, KMAX, -1, 1'b1);
            vecs++;
            if (obs !== e) begin
                fails++;
                $display("FAIL kmax cyc %0d: got %b want %b", i, obs, e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Reset in STREAM cycle 5 (idx 9), then a clean K=2 tile.
    task automatic test_reset_mid();
        logic [7:0] e;
        begin_tile(4);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            #1;
            if (i == 9) begin
                rstn = 1'b0;
                #1;
                e = 8'h00;
            end else begin
                e = exp_out(i, 4, 4, -1, 1'b1);
            end
            vecs++;
            if (obs !== e) begin
                fails++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", i, obs, e);
            end
            @(negedge clk);
        end
        rstn = 1'b1;
        begin_tile(2);
        for (int i = 0; i < 21; i++) begin
            in_valid = 1'b1;
            #1;
            e = exp_out(i, 2, 2, -1, 1'b1);
            vecs++;
            if (obs !== e) begin
                fails++;
                $display("FAIL after_reset cyc %0d: got %b want %b", i, obs, e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_underrun();
        logic [7:0] e;
        // Empties outside the checked window (LOAD, stream cycles >= K) or on a row
        // other than 0 never raise the flag.
        begin_tile(4);
        for (int i = 0; i < 26; i++) begin
            in_valid = 1'b1;
            aemptys  = (i == 4) ? 8'h08 : 8'h00;
            wemptys  = (i < 4 || i >= 8) ? 8'h01 : 8'h00;
            #1;
            e = exp_out(i, 4, 4, -1, 1'b1);
            vecs++;
            if (obs !== e) begin
                fails++;
                $display("FAIL underrun_quiet cyc %0d: got %b want %b", i, obs, e);
            end
            @(negedge clk);
        end
        aemptys = '0;
        wemptys = '0;
        // aemptys[0] on STREAM cycle 1 (idx 5): flag visible from idx 6, sticky into IDLE.
        begin_tile(4);
        for (int i = 0; i < 26; i++) begin
            in_valid = 1'b1;
            aemptys  = (i == 5) ? 8'h01 : 8'h00;
            #1;
            e = exp_out(i, 4, 4, CHK ? 6 : -1, 1'b1);
            vecs++;
            if (obs !== e) begin
                fails++;
                $display("FAIL underrun cyc %0d: got %b want %b", i, obs, e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        aemptys  = '0;
        rstn = 1'b0;
        #1;
        vecs++;
        if (obs !== 8'h00) begin
            fails++;
            $display("FAIL underrun_reset: got %b want %b", obs, 8'h00);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        vecs++;
        if (underrun !== 1'b0) begin
            fails++;
            $display("FAIL underrun_clear: got %b want %b", underrun, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ignore();
        test_kmax();
        test_reset_mid();
        test_underrun();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
